hc_read_arbiter: RTL and testbench
==================================

Name: hc_read_arbiter

Overview:
Shares the single buffer read-request channel between NUM_REQ independent requesters, such as accelerator lanes each streaming a different buffer. Each cycle it grants at most one indexed read (buffer id, line offset) in round-robin order. It tags each issued read with the requester index and steers each read response back to the owner. Per-requester outstanding reads are bounded, and the block supports a run/drain sequence, so it sits between the accelerator kernels and the buffer read port.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
BUF_ID_W, 4, buffer index width (covers HC_BUFFER_SIZE)
OFF_W, 32, line offset width (matches t_request_cmd_offset)
DATA_W, 512, read response data width (one cache line)
MAX_OUT, 8, max in-flight reads per requester (power of 2)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  pulse: leave IDLE, begin arbitration
stop  in  1  pulse: stop granting, drain in-flight reads
done  out  1  high for 1 cycle when drain completes
req_valid  in  NUM_REQ  per-requester read request
req_buffer  in  NUM_REQ*BUF_ID_W  buffer index, packed by requester
req_offset  in  NUM_REQ*OFF_W  line offset, packed by requester
req_ready  out  NUM_REQ  one-hot grant; request accepted this cycle
rd_valid  out  1  read request to buffer port
rd_buffer  out  BUF_ID_W  buffer index of issued read
rd_offset  out  OFF_W  offset of issued read
rd_tag  out  $clog2(NUM_REQ)  requester id carried as mdata
rd_almost_full  in  1  buffer port back-pressure
rsp_valid  in  1  read response valid
rsp_tag  in  $clog2(NUM_REQ)  returned mdata
rsp_data  in  DATA_W  response line
out_valid  out  NUM_REQ  one-hot response strobe to owner
out_data  out  DATA_W  registered copy of rsp_data

Behaviour:
- Reset, asynchronous: state=IDLE, all outputs 0, rr pointer=0, all outstanding counters=0.
- FSM IDLE -> RUN on start; RUN -> DRAIN on stop; DRAIN -> IDLE when all counters are 0, pulsing done in that transition cycle. start is ignored outside IDLE; stop is ignored outside RUN.
- Eligible requester i: req_valid[i] && cnt[i] < MAX_OUT.
- Grant happens only in RUN and only when rd_almost_full=0.
- Grant selection: the first eligible requester at or after the rr pointer, wrapping modulo NUM_REQ. req_ready is combinational, one-hot, and applies in the same cycle.
- After a grant to i, the rr pointer becomes (i+1) mod NUM_REQ. Otherwise the pointer holds.
- rd_valid/rd_buffer/rd_offset/rd_tag are registered, so they appear 1 cycle after the grant. rd_valid deasserts in the following cycle if there is no grant.
- Response routing: out_valid[rsp_tag] and out_data are registered, with 1-cycle latency. out_valid is 0 when there is no rsp_valid.
- Counter update: cnt[i] += grant to i; cnt[i] -= (rsp_valid && rsp_tag==i). A grant and a response to the same i in the same cycle leave cnt unchanged. The counter never wraps.
- A response arriving while cnt[tag]==0 is a protocol error: it is dropped (no out_valid, counter held at 0) and an assertion fires.
- In DRAIN and IDLE, responses are still routed and counted; no grants are issued.
- Reset mid-operation clears all state immediately; in-flight responses arriving after reset are dropped under the rule above.

Decomposition:
- hc_pkg gains: HC_ARB_NUM_REQ, HC_ARB_MAX_OUT, t_arb_tag (tag typedef), t_arb_state enum {ARB_IDLE, ARB_RUN, ARB_DRAIN}. Existing t_request_cmd_offset is reused for offsets.
- One sub-module, hc_rr_arbiter: a parameterized round-robin picker. It takes an eligible vector and pointer and produces a one-hot grant and next pointer, purely combinational. Top level holds the FSM, counters, and output registers.

Test Plan:
- Reset then start; only req_valid[2]=1 with buf=1, off=5 -> req_ready=4'b0100; next cycle rd_valid=1, rd_buffer=1, rd_offset=5, rd_tag=2.
- All 4 requesters valid continuously, rd_almost_full=0 -> grants cycle 0,1,2,3,0,...; exactly 1 grant per cycle.
- Requester 0 only, no responses, MAX_OUT=8 -> exactly 8 grants, then req_ready[0] stays 0. A single rsp with tag 0 restores one grant.
- rd_almost_full=1 for 5 cycles with all requesters valid -> no req_ready, rd_valid=0, rr pointer unchanged. Deassert -> grant resumes at the pointer.
- Grant to 1 and rsp_tag=1 in the same cycle with cnt[1]=3 -> cnt[1] stays 3; out_valid=4'b0010 next cycle with matching data.
- 3 reads in flight, pulse stop -> no further grants; done pulses once in the cycle after the 3rd response is accepted; state returns to IDLE.

Source files
------------

// File: rtl/hc_pkg.sv
// Shared types and constants for the hc buffer datapath.
// Holds the request offset type and the read-arbiter tag/state types.
package hc_pkg;

    localparam int HC_BUFFER_SIZE = 16;

    typedef logic [31:0] t_request_cmd_offset;

    localparam int HC_ARB_NUM_REQ = 4;
    localparam int HC_ARB_MAX_OUT = 8;

    typedef logic [$clog2(HC_ARB_NUM_REQ)-1:0] t_arb_tag;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_RUN,
        ARB_DRAIN
    } t_arb_state;

endpackage

// File: rtl/hc_rr_arbiter.sv
// Combinational round-robin picker: first eligible index at or after ptr.
// Ports: eligible (N), ptr (TAG_W) in; one-hot grant (N), next_ptr (TAG_W) out.
module hc_rr_arbiter
    import hc_pkg::*;
#(
    parameter int N     = HC_ARB_NUM_REQ,
    parameter int TAG_W = $clog2(N)
) (
    input  logic [N-1:0]     eligible,
    input  logic [TAG_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [TAG_W-1:0] next_ptr
);

    logic             found;
    logic [TAG_W-1:0] idx;

    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        found    = 1'b0;
        idx      = '0;
        for (int k = 0; k < N; k++) begin
            idx = TAG_W'((int'(ptr) + k) % N);
            if (!found && eligible[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                next_ptr   = TAG_W'((int'(idx) + 1) % N);
            end
        end
    end

endmodule

// File: rtl/hc_read_arbiter.sv
// Shares one buffer read-request channel among NUM_REQ requesters, round-robin.
// Ports: start/stop/done control; req_* per-requester requests with one-hot
// req_ready; rd_* registered read issue with requester tag; rsp_* responses
// steered back as one-hot out_valid with registered out_data.
module hc_read_arbiter
    import hc_pkg::*;
#(
    parameter  int NUM_REQ  = HC_ARB_NUM_REQ,
    parameter  int BUF_ID_W = 4,
    parameter  int OFF_W    = $bits(t_request_cmd_offset),
    parameter  int DATA_W   = 512,
    parameter  int MAX_OUT  = HC_ARB_MAX_OUT,
    localparam int TAG_W    = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        stop,
    output logic                        done,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*BUF_ID_W-1:0] req_buffer,
    input  logic [NUM_REQ*OFF_W-1:0]    req_offset,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        rd_valid,
    output logic [BUF_ID_W-1:0]         rd_buffer,
    output logic [OFF_W-1:0]            rd_offset,
    output logic [TAG_W-1:0]            rd_tag,
    input  logic                        rd_almost_full,
    input  logic                        rsp_valid,
    input  logic [TAG_W-1:0]            rsp_tag,
    input  logic [DATA_W-1:0]           rsp_data,
    output logic [NUM_REQ-1:0]          out_valid,
    output logic [DATA_W-1:0]           out_data
);

    // One extra bit so a counter can hold MAX_OUT itself.
    localparam int CNT_W = $clog2(MAX_OUT) + 1;

    t_arb_state state, state_nxt;

    logic [TAG_W-1:0]    ptr, ptr_nxt;
    logic [CNT_W-1:0]    cnt [NUM_REQ];
    logic [NUM_REQ-1:0]  eligible;
    logic [NUM_REQ-1:0]  grant;
    logic [NUM_REQ-1:0]  rsp_hit;
    logic [NUM_REQ-1:0]  cnt_zero;
    logic                grant_en;
    logic [TAG_W-1:0]    gnt_idx;
    logic [BUF_ID_W-1:0] buf_sel;
    logic [OFF_W-1:0]    off_sel;

    assign grant_en = (state == ARB_RUN) && !rd_almost_full;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        assign cnt_zero[i] = (cnt[i] == '0);
        assign eligible[i] = grant_en && req_valid[i]
                           && (cnt[i] < CNT_W'(MAX_OUT));
        // A response to a requester with nothing in flight is dropped here.
        assign rsp_hit[i]  = rsp_valid && (rsp_tag == TAG_W'(i))
                           && !cnt_zero[i];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt[i] <= '0;
            end else if (grant[i] && !rsp_hit[i]) begin
                cnt[i] <= cnt[i] + CNT_W'(1);
            end else if (!grant[i] && rsp_hit[i]) begin
                cnt[i] <= cnt[i] - CNT_W'(1);
            end
        end
    end

    hc_rr_arbiter #(
        .N     (NUM_REQ),
        .TAG_W (TAG_W)
    ) u_rr (
        .eligible (eligible),
        .ptr      (ptr),
        .grant    (grant),
        .next_ptr (ptr_nxt)
    );

    assign req_ready = grant;

    always_comb begin
        buf_sel = '0;
        off_sel = '0;
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                buf_sel = req_buffer[i*BUF_ID_W +: BUF_ID_W];
                off_sel = req_offset[i*OFF_W +: OFF_W];
                gnt_idx = TAG_W'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        unique case (state)
            ARB_IDLE:  if (start) state_nxt = ARB_RUN;
            ARB_RUN:   if (stop)  state_nxt = ARB_DRAIN;
            ARB_DRAIN: begin
                if (&cnt_zero) begin
                    state_nxt = ARB_IDLE;
                    done      = 1'b1;
                end
            end
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ARB_IDLE;
            ptr       <= '0;
            rd_valid  <= 1'b0;
            rd_buffer <= '0;
            rd_offset <= '0;
            rd_tag    <= '0;
            out_valid <= '0;
            out_data  <= '0;
        end else begin
            state     <= state_nxt;
            rd_valid  <= |grant;
            out_valid <= rsp_hit;
            if (|grant) begin
                ptr       <= ptr_nxt;
                rd_buffer <= buf_sel;
                rd_offset <= off_sel;
                rd_tag    <= gnt_idx;
            end
            if (rsp_valid) begin
                out_data <= rsp_data;
            end
        end
    end

    a_rsp_owned: assert property (
        @(posedge clk) disable iff (reset)
        rsp_valid |-> |rsp_hit
    );

endmodule

// File: tb/tb_hc_read_arbiter.sv
// Self-checking bench for hc_read_arbiter with a cycle model and scoreboard.
// Expected read issues and responses are queued per cycle and popped next cycle.
module tb_hc_read_arbiter;
    import hc_pkg::*;

    localparam int N  = 4;
    localparam int BW = 4;
    localparam int OW = 32;
    localparam int DW = 512;
    localparam int MO = 8;

    typedef struct {
        logic          v;
        logic [BW-1:0] b;
        logic [OW-1:0] o;
        logic [1:0]    t;
    } rd_exp_t;

    typedef struct {
        logic [N-1:0]  v;
        logic [DW-1:0] d;
    } out_exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, stop, done;
    logic [N-1:0]  req_valid, req_ready;
    logic [N*BW-1:0] req_buffer;
    logic [N*OW-1:0] req_offset;
    logic          rd_valid;
    logic [BW-1:0] rd_buffer;
    logic [OW-1:0] rd_offset;
    logic [1:0]    rd_tag;
    logic          rd_almost_full;
    logic          rsp_valid;
    logic [1:0]    rsp_tag;
    logic [DW-1:0] rsp_data;
    logic [N-1:0]  out_valid;
    logic [DW-1:0] out_data;

    hc_read_arbiter #(
        .NUM_REQ  (N),
        .BUF_ID_W (BW),
        .OFF_W    (OW),
        .DATA_W   (DW),
        .MAX_OUT  (MO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .stop           (stop),
        .done           (done),
        .req_valid      (req_valid),
        .req_buffer     (req_buffer),
        .req_offset     (req_offset),
        .req_ready      (req_ready),
        .rd_valid       (rd_valid),
        .rd_buffer      (rd_buffer),
        .rd_offset      (rd_offset),
        .rd_tag         (rd_tag),
        .rd_almost_full (rd_almost_full),
        .rsp_valid      (rsp_valid),
        .rsp_tag        (rsp_tag),
        .rsp_data       (rsp_data),
        .out_valid      (out_valid),
        .out_data       (out_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_state, m_ptr;
    int m_cnt [N];
    int gcnt [N];
    int last_g;
    rd_exp_t  rd_q [$];
    out_exp_t out_q [$];

    task automatic chk(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd_line();
        logic [DW-1:0] l;
        for (int k = 0; k < DW/32; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic bit all_idle_cnt();
        for (int i = 0; i < N; i++) if (m_cnt[i] != 0) return 0;
        return 1;
    endfunction

    task automatic rnd_fields();
        for (int i = 0; i < N; i++) begin
            req_buffer[i*BW +: BW] = BW'($urandom);
            req_offset[i*OW +: OW] = $urandom;
        end
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic tick();
        rd_exp_t  e;
        out_exp_t o;
        int       g;
        logic [N-1:0] eg;
        #1;
        e = rd_q.pop_front();
        chk("rd_valid", rd_valid, e.v);
        if (e.v) begin
            chk("rd_buffer", rd_buffer, e.b);
            chk("rd_offset", rd_offset, e.o);
            chk("rd_tag", rd_tag, e.t);
        end
        o = out_q.pop_front();
        chk("out_valid", out_valid, o.v);
        if (o.v != 0) chk("out_data", out_data, o.d);
        g = -1;
        if (m_state == 1 && !rd_almost_full) begin
            for (int k = 0; k < N; k++) begin
                int i;
                i = (m_ptr + k) % N;
                if (g < 0 && req_valid[i] && m_cnt[i] < MO) g = i;
            end
        end
        eg = (g >= 0) ? N'(1) << g : '0;
        chk("req_ready", req_ready, eg);
        chk("done", done, m_state == 2 && all_idle_cnt());
        e.v = (g >= 0);
        e.b = '0;
        e.o = '0;
        e.t = '0;
        if (g >= 0) begin
            e.b = req_buffer[g*BW +: BW];
            e.o = req_offset[g*OW +: OW];
            e.t = 2'(g);
        end
        rd_q.push_back(e);
        o.v = (rsp_valid && m_cnt[rsp_tag] > 0) ? N'(1) << rsp_tag : '0;
        o.d = rsp_data;
        out_q.push_back(o);
        if (m_state == 2 && all_idle_cnt()) m_state = 0;
        else if (m_state == 1 && stop) m_state = 2;
        else if (m_state == 0 && start) m_state = 1;
        if (o.v != 0) m_cnt[rsp_tag]--;
        if (g >= 0) begin
            m_cnt[g]++;
            gcnt[g]++;
            last_g = g;
            m_ptr = (g + 1) % N;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pick_rsp();
        rsp_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (m_cnt[i] > 0) begin
                rsp_valid = 1'b1;
                rsp_tag   = 2'(i);
            end
        end
        rsp_data = rnd_line();
    endtask

    task automatic flush();
        req_valid = '0;
        for (int c = 0; c < 40; c++) begin
            if (all_idle_cnt()) break;
            pick_rsp();
            tick();
        end
        rsp_valid = 1'b0;
        chk("flush_empty", all_idle_cnt(), 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int base, prev;
        int af_ptr;
        logic [DW-1:0] d;
        reset          = 1'b1;
        start          = 1'b0;
        stop           = 1'b0;
        req_valid      = '0;
        req_buffer     = '0;
        req_offset     = '0;
        rd_almost_full = 1'b0;
        rsp_valid      = 1'b0;
        rsp_tag        = '0;
        rsp_data       = '0;
        m_state = 0;
        m_ptr   = 0;
        last_g  = -1;
        for (int i = 0; i < N; i++) begin
            m_cnt[i] = 0;
            gcnt[i]  = 0;
        end
        repeat (3) @(negedge clk);
        #1;
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_rd_buffer", rd_buffer, '0);
        chk("rst_rd_offset", rd_offset, '0);
        chk("rst_rd_tag", rd_tag, '0);
        chk("rst_out_valid", out_valid, '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_done", done, 1'b0);
        chk("rst_req_ready", req_ready, '0);
        reset = 1'b0;
        @(negedge clk);
        rd_q.push_back('{1'b0, '0, '0, '0});
        out_q.push_back('{'0, '0});

        // single requester, fixed fields
        start = 1'b1;
        tick();
        start = 1'b0;
        req_valid = 4'b0100;
        req_buffer[2*BW +: BW] = 4'd1;
        req_offset[2*OW +: OW] = 32'd5;
        #1 chk("t1_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        #1;
        chk("t1_rd_valid", rd_valid, 1'b1);
        chk("t1_rd_buffer", rd_buffer, 4'd1);
        chk("t1_rd_offset", rd_offset, 32'd5);
        chk("t1_rd_tag", rd_tag, 2'd2);
        tick();

        // all requesters: strict rotation after lane 2
        req_valid = 4'b1111;
        prev = 2;
        for (int c = 0; c < 12; c++) begin
            rnd_fields();
            pick_rsp();
            prev = (prev + 1) % N;
            #1;
            chk("t2_rotate", req_ready, N'(1) << prev);
            chk("t2_onehot", $countones(req_ready), 1);
            tick();
        end
        flush();

        // saturate requester 0
        req_valid = 4'b0001;
        base = gcnt[0];
        for (int c = 0; c < 12; c++) begin
            rnd_fields();
            tick();
        end
        chk("t3_grants", gcnt[0] - base, MO);
        #1 chk("t3_blocked", req_ready[0], 1'b0);
        rsp_valid = 1'b1;
        rsp_tag   = 2'd0;
        rsp_data  = rnd_line();
        tick();
        rsp_valid = 1'b0;
        base = gcnt[0];
        repeat (4) tick();
        chk("t3_one_more", gcnt[0] - base, 1);
        flush();

        // back-pressure holds pointer (last grant was lane 0)
        af_ptr = 1;
        req_valid = 4'b1111;
        rd_almost_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            rnd_fields();
            #1 chk("t4_noready", req_ready, '0);
            if (c > 0) chk("t4_rd_idle", rd_valid, 1'b0);
            tick();
        end
        rd_almost_full = 1'b0;
        #1 chk("t4_resume", req_ready, N'(1) << af_ptr);
        repeat (3) tick();
        flush();

        // simultaneous grant and response on lane 1
        req_valid = 4'b0010;
        repeat (3) begin
            rnd_fields();
            tick();
        end
        chk("t5_cnt_setup", m_cnt[1], 3);
        d = rnd_line();
        rsp_valid = 1'b1;
        rsp_tag   = 2'd1;
        rsp_data  = d;
        #1 chk("t5_ready", req_ready, 4'b0010);
        tick();
        rsp_valid = 1'b0;
        #1;
        chk("t5_out_valid", out_valid, 4'b0010);
        chk("t5_out_data", out_data, d);
        base = gcnt[1];
        repeat (8) tick();
        chk("t5_room", gcnt[1] - base, MO - 3);
        flush();

        // drain with three reads in flight
        req_valid = 4'b1000;
        repeat (3) tick();
        req_valid = '0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        req_valid = 4'b1111;
        for (int r = 0; r < 3; r++) begin
            rsp_valid = 1'b1;
            rsp_tag   = 2'd3;
            rsp_data  = rnd_line();
            #1;
            chk("t6_nogrant", req_ready, '0);
            chk("t6_no_done", done, 1'b0);
            tick();
        end
        rsp_valid = 1'b0;
        #1 chk("t6_done", done, 1'b1);
        tick();
        #1;
        chk("t6_done_once", done, 1'b0);
        chk("t6_idle", req_ready, '0);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        #1 chk("t6_restart", req_ready, 4'b0001);
        tick();
        flush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
